// File: rtl/srff_pkg.sv
// Shared types and defaults for the SR flip-flop driver.
package srff_pkg;

  localparam int unsigned CntWidth        = 8;
  localparam int unsigned CheckDlyDefault = 1;
  localparam int unsigned MaxRetryDefault = 3;

  typedef logic [CntWidth-1:0] cnt_t;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StDrive,
    StWait,
    StCheck,
    StFault
  } state_e;

endpackage

// File: rtl/srff_driver_if.sv
// Target handshake, flip-flop excitation/feedback and status bundle.
interface srff_driver_if;
  import srff_pkg::*;

  logic tgt_valid;
  logic tgt;
  logic tgt_ready;
  logic q_fb;
  logic qn_fb;
  logic s;
  logic r;
  logic ff_clr;
  logic clr_err;
  logic busy;
  logic err;
  cnt_t mismatch_cnt;
  cnt_t wr_cnt;

  modport master (
    output tgt_valid, tgt, q_fb, qn_fb, clr_err,
    input  tgt_ready, s, r, ff_clr, busy, err, mismatch_cnt, wr_cnt
  );

  modport slave (
    input  tgt_valid, tgt, q_fb, qn_fb, clr_err,
    output tgt_ready, s, r, ff_clr, busy, err, mismatch_cnt, wr_cnt
  );

endinterface

// File: rtl/sat_cnt8.sv
// 8-bit counter that saturates at 255; clear has priority over increment.
module sat_cnt8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [7:0] cnt_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != 8'hff)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/srff_driver.sv
// Drives an external SR flip-flop to a requested state, verifies it via Q/QN
// feedback and retries a bounded number of times before latching a fault.
module srff_driver
  import srff_pkg::*;
#(
  parameter int unsigned CHECK_DLY = CheckDlyDefault,
  parameter int unsigned MAX_RETRY = MaxRetryDefault
) (
  input logic          clk,
  input logic          rst_n,
  srff_driver_if.slave bus
);

  state_e     state_q, state_d;
  logic       tgt_q, tgt_d;
  logic       qt_q, qt_d;
  logic [2:0] retry_q, retry_d;
  logic [2:0] wait_q, wait_d;
  logic       s_q, r_q, ff_clr_q, ready_q, busy_q, err_q;
  logic       err_d;
  cnt_t       wr_cnt_q, wr_cnt_d;
  logic       fb_ok, check_fail;

  assign fb_ok      = (bus.q_fb == tgt_q) && (bus.qn_fb == ~tgt_q);
  assign check_fail = (state_q == StCheck) && !fb_ok;

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    qt_d     = qt_q;
    retry_d  = retry_q;
    wait_d   = wait_q;
    unique case (state_q)
      // Hold INIT for the one cycle in which the clear pulse is visible.
      StInit: begin
        qt_d = 1'b0;
        if (ff_clr_q) state_d = StIdle;
      end
      StIdle: begin
        if (bus.tgt_valid && ready_q) begin
          retry_d = '0;
          if (bus.tgt != qt_q) begin
            tgt_d   = bus.tgt;
            state_d = StDrive;
          end
        end
      end
      StDrive: begin
        if (CHECK_DLY <= 1) begin
          state_d = StCheck;
        end else begin
          state_d = StWait;
          wait_d  = 3'(CHECK_DLY - 2);
        end
      end
      StWait: begin
        if (wait_q == '0) state_d = StCheck;
        else              wait_d  = wait_q - 3'd1;
      end
      StCheck: begin
        if (fb_ok) begin
          qt_d    = tgt_q;
          state_d = StIdle;
        end else if (retry_q < 3'(MAX_RETRY)) begin
          retry_d = retry_q + 3'd1;
          state_d = StDrive;
        end else begin
          state_d = StFault;
        end
      end
      StFault: begin
        if (bus.clr_err) begin
          qt_d    = bus.q_fb;
          state_d = StIdle;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (state_d == StDrive) wr_cnt_d = wr_cnt_q + cnt_t'(1);
    err_d = err_q;
    if (bus.clr_err)     err_d = 1'b0;
    else if (check_fail) err_d = 1'b1;
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StInit;
      tgt_q    <= 1'b0;
      qt_q     <= 1'b0;
      retry_q  <= '0;
      wait_q   <= '0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      ff_clr_q <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
      err_q    <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      qt_q     <= qt_d;
      retry_q  <= retry_d;
      wait_q   <= wait_d;
      s_q      <= (state_d == StDrive) && tgt_d;
      r_q      <= (state_d == StDrive) && !tgt_d;
      ff_clr_q <= (state_q == StInit) && !ff_clr_q;
      ready_q  <= (state_d == StIdle);
      busy_q   <= (state_d != StIdle);
      err_q    <= err_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  sat_cnt8 u_mismatch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (check_fail),
    .clr_i (bus.clr_err),
    .cnt_o (bus.mismatch_cnt)
  );

  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.ff_clr    = ff_clr_q;
  assign bus.tgt_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_srff_driver.sv
// Directed bench: one DUT with CHECK_DLY=1, one with CHECK_DLY=3, each with an SR flop model.
module tb_srff_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tgt_valid1 = 1'b0;
  logic tgt_valid3 = 1'b0;
  logic tgt = 1'b0;
  logic clr_err = 1'b0;
  logic stuck1 = 1'b0;
  logic stuck3 = 1'b0;
  logic q1 = 1'b0;
  logic q3 = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  srff_driver_if if1 ();
  srff_driver_if if3 ();

  assign if1.tgt_valid = tgt_valid1;
  assign if1.tgt       = tgt;
  assign if1.clr_err   = clr_err;
  assign if1.q_fb      = stuck1 ? 1'b0 : q1;
  assign if1.qn_fb     = ~if1.q_fb;
  assign if3.tgt_valid = tgt_valid3;
  assign if3.tgt       = tgt;
  assign if3.clr_err   = clr_err;
  assign if3.q_fb      = stuck3 ? 1'b0 : q3;
  assign if3.qn_fb     = ~if3.q_fb;

  srff_driver #(.CHECK_DLY(1), .MAX_RETRY(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  srff_driver #(.CHECK_DLY(3), .MAX_RETRY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  // SR flip-flop models: clear dominates, then set, then reset.
  always @(posedge clk) begin
    if (if1.ff_clr) q1 <= 1'b0; else if (if1.s) q1 <= 1'b1; else if (if1.r) q1 <= 1'b0;
    if (if3.ff_clr) q3 <= 1'b0; else if (if3.s) q3 <= 1'b1; else if (if3.r) q3 <= 1'b0;
  end

  always @(posedge clk) begin
    assert (!(if1.s && if1.r) && !(if3.s && if3.r))
    else begin
      failures++;
      $display("FAIL s_r_exclusive: s1=%b r1=%b s3=%b r3=%b", if1.s, if1.r, if3.s, if3.r);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (if1.ff_clr !== 1'b0) begin failures++; $display("FAIL rst_ffclr: got %b want 0", if1.ff_clr); end
    checks++; if (if1.tgt_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b want 0", if1.tgt_ready); end
    checks++; if ({if1.s, if1.r, if1.err} !== 3'b000) begin failures++; $display("FAIL rst_sre: got %b want 000", {if1.s, if1.r, if1.err}); end
    rst_n = 1'b1;
    tick();
    checks++; if (if1.ff_clr !== 1'b1) begin failures++; $display("FAIL init_ffclr: got %b want 1", if1.ff_clr); end
    checks++; if (if1.busy !== 1'b1) begin failures++; $display("FAIL init_busy: got %b want 1", if1.busy); end
    tick();
    checks++; if (if1.ff_clr !== 1'b0) begin failures++; $display("FAIL idle_ffclr: got %b want 0", if1.ff_clr); end
    checks++; if ({if1.tgt_ready, if1.busy} !== 2'b10) begin failures++; $display("FAIL idle_ready_busy: got %b want 10", {if1.tgt_ready, if1.busy}); end
    checks++; if ({if1.wr_cnt, if1.mismatch_cnt} !== 16'h0000) begin failures++; $display("FAIL idle_cnts: got %h want 0000", {if1.wr_cnt, if1.mismatch_cnt}); end
  endtask

  task automatic test_set();
    tgt_valid1 = 1'b1;
    tgt = 1'b1;
    tick();
    tgt_valid1 = 1'b0;
    checks++; if ({if1.s, if1.r} !== 2'b10) begin failures++; $display("FAIL set_pulse: got %b want 10", {if1.s, if1.r}); end
    checks++; if (if1.wr_cnt !== 8'd1) begin failures++; $display("FAIL set_wrcnt: got %0d want 1", if1.wr_cnt); end
    tick();
    checks++; if ({if1.s, if1.busy, if1.tgt_ready} !== 3'b010) begin failures++; $display("FAIL set_check: got %b want 010", {if1.s, if1.busy, if1.tgt_ready}); end
    tick();
    checks++; if ({if1.tgt_ready, if1.err} !== 2'b10) begin failures++; $display("FAIL set_idle: got %b want 10", {if1.tgt_ready, if1.err}); end
  endtask

  task automatic test_same_target();
    tgt_valid1 = 1'b1;
    tgt = 1'b1;
    tick();
    tgt_valid1 = 1'b0;
    checks++; if ({if1.s, if1.r, if1.tgt_ready} !== 3'b001) begin failures++; $display("FAIL same_nopulse: got %b want 001", {if1.s, if1.r, if1.tgt_ready}); end
    checks++; if (if1.wr_cnt !== 8'd1) begin failures++; $display("FAIL same_wrcnt: got %0d want 1", if1.wr_cnt); end
  endtask

  task automatic test_back_to_back();
    tgt_valid1 = 1'b1;
    tgt = 1'b0;
    tick();
    tgt = 1'b1; // offered while busy: must wait for IDLE
    checks++; if ({if1.s, if1.r} !== 2'b01) begin failures++; $display("FAIL b2b_r: got %b want 01", {if1.s, if1.r}); end
    tick();
    checks++; if ({if1.s, if1.r, if1.wr_cnt} !== {2'b00, 8'd2}) begin failures++; $display("FAIL b2b_ignored: got %b/%0d want 00/2", {if1.s, if1.r}, if1.wr_cnt); end
    tick();
    checks++; if (if1.tgt_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b want 1", if1.tgt_ready); end
    tick();
    tgt_valid1 = 1'b0;
    checks++; if ({if1.s, if1.wr_cnt} !== {1'b1, 8'd3}) begin failures++; $display("FAIL b2b_second: got %b/%0d want 1/3", if1.s, if1.wr_cnt); end
    tick();
    tick();
  endtask

  task automatic test_stuck_fault();
    int pulses = 0;
    do_reset();
    stuck1 = 1'b1;
    tgt_valid1 = 1'b1;
    tgt = 1'b1;
    tick();
    tgt_valid1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (if1.s) pulses++;
      tick();
    end
    checks++; if (pulses != 4) begin failures++; $display("FAIL stuck_pulses: got %0d want 4", pulses); end
    checks++; if (if1.mismatch_cnt !== 8'd4) begin failures++; $display("FAIL stuck_mcnt: got %0d want 4", if1.mismatch_cnt); end
    checks++; if ({if1.err, if1.tgt_ready, if1.busy, if1.s} !== 4'b1010) begin failures++; $display("FAIL stuck_fault: got %b want 1010", {if1.err, if1.tgt_ready, if1.busy, if1.s}); end
    tick();
    tick();
    tick();
    checks++; if ({if1.tgt_ready, if1.s, if1.wr_cnt} !== {2'b00, 8'd4}) begin failures++; $display("FAIL fault_hold: got %b/%0d want 00/4", {if1.tgt_ready, if1.s}, if1.wr_cnt); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if ({if1.tgt_ready, if1.err, if1.mismatch_cnt} !== {2'b10, 8'd0}) begin failures++; $display("FAIL clr_exit: got %b/%0d want 10/0", {if1.tgt_ready, if1.err}, if1.mismatch_cnt); end
    // QT was reloaded from feedback (0): a request for 0 produces no pulse.
    tgt_valid1 = 1'b1;
    tgt = 1'b0;
    tick();
    tgt_valid1 = 1'b0;
    checks++; if ({if1.r, if1.tgt_ready, if1.wr_cnt} !== {2'b01, 8'd4}) begin failures++; $display("FAIL clr_qt: got %b/%0d want 01/4", {if1.r, if1.tgt_ready}, if1.wr_cnt); end
  endtask

  task automatic test_clr_coincide();
    tgt_valid1 = 1'b1;
    tgt = 1'b1;
    tick();
    tgt_valid1 = 1'b0;
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if ({if1.err, if1.mismatch_cnt} !== {1'b0, 8'd0}) begin failures++; $display("FAIL coincide_clr: got %b/%0d want 0/0", if1.err, if1.mismatch_cnt); end
    checks++; if (if1.s !== 1'b1) begin failures++; $display("FAIL coincide_retry: got %b want 1", if1.s); end
    stuck1 = 1'b0;
    do_reset();
  endtask

  task automatic test_check_dly3();
    tgt_valid3 = 1'b1;
    tgt = 1'b1;
    tick();
    tgt_valid3 = 1'b0;
    stuck3 = 1'b1;
    checks++; if ({if3.s, if3.wr_cnt} !== {1'b1, 8'd1}) begin failures++; $display("FAIL dly3_pulse: got %b/%0d want 1/1", if3.s, if3.wr_cnt); end
    tick();
    tick();
    checks++; if ({if3.s, if3.busy, if3.err} !== 3'b010) begin failures++; $display("FAIL dly3_wait: got %b want 010", {if3.s, if3.busy, if3.err}); end
    tick();
    stuck3 = 1'b0;
    tick();
    checks++; if ({if3.tgt_ready, if3.err, if3.mismatch_cnt} !== {2'b10, 8'd0}) begin failures++; $display("FAIL dly3_sample: got %b/%0d want 10/0", {if3.tgt_ready, if3.err}, if3.mismatch_cnt); end
  endtask

  task automatic test_reset_mid_drive();
    tgt_valid1 = 1'b1;
    tgt = 1'b1;
    tick();
    tgt_valid1 = 1'b0;
    checks++; if (if1.s !== 1'b1) begin failures++; $display("FAIL mid_pre: got %b want 1", if1.s); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({if1.s, if1.r, if1.wr_cnt} !== {2'b00, 8'd0}) begin failures++; $display("FAIL mid_async: got %b/%0d want 00/0", {if1.s, if1.r}, if1.wr_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (if1.ff_clr !== 1'b1) begin failures++; $display("FAIL mid_init: got %b want 1", if1.ff_clr); end
    tick();
  endtask

  task automatic test_wrap();
    logic qt = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tgt_valid1 = 1'b1;
      tgt = ~qt;
      qt = ~qt;
      tick();
      tgt_valid1 = 1'b0;
      tick();
      tick();
      if (i == 255) begin
        checks++; if (if1.wr_cnt !== 8'd0) begin failures++; $display("FAIL wrap_256: got %0d want 0", if1.wr_cnt); end
      end
    end
    checks++; if (if1.wr_cnt !== 8'd44) begin failures++; $display("FAIL wrap_300: got %0d want 44", if1.wr_cnt); end
    checks++; if ({if1.err, if1.mismatch_cnt} !== {1'b0, 8'd0}) begin failures++; $display("FAIL wrap_err: got %b/%0d want 0/0", if1.err, if1.mismatch_cnt); end
  endtask

  initial begin
    test_reset();
    test_set();
    test_same_target();
    test_back_to_back();
    test_stuck_fault();
    test_clr_coincide();
    test_check_dly3();
    test_reset_mid_drive();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
